alu_wide_seq: RTL and testbench

Sequencer that runs 64-bit operations on the existing 32-bit combinational ALU. Each operation takes two ALU beats: low word first, then high word, with the carry chained between them. It sits between a requester (valid/ready) and the ALU's EXE_CMD/Val1/Val2/C inputs and ALU_Result/SR outputs. It accumulates the 64-bit result and the combined NZCV flags.

---
 rtl/alu_wide_seq_if.sv | 39 +++
 rtl/alu_wide_seq.sv | 190 +++++++++++++++++++
 tb/tb_alu_wide_seq.sv | 225 ++++++++++++++++++++++
 3 files changed

// File: rtl/alu_wide_seq_if.sv
// Request/response and ALU-side signal bundle for the 64-bit-on-32-bit ALU sequencer.
interface alu_wide_seq_if #(
    parameter int unsigned WIDTH = 32
);
    // Requester side
    logic                 req_valid;
    logic                 req_ready;
    logic [3:0]           req_op;
    logic [2*WIDTH-1:0]   req_a;
    logic [2*WIDTH-1:0]   req_b;
    logic                 req_cin;

    // Response side
    logic                 rsp_valid;
    logic                 rsp_ready;
    logic [2*WIDTH-1:0]   rsp_data;
    logic [3:0]           rsp_sr;
    logic                 rsp_err;

    // ALU side
    logic [3:0]           EXE_CMD;
    logic [WIDTH-1:0]     Val1;
    logic [WIDTH-1:0]     Val2;
    logic                 C;
    logic [WIDTH-1:0]     ALU_Result;
    logic [3:0]           SR;

    // Requester plus ALU environment
    modport master (
        output req_valid, req_op, req_a, req_b, req_cin, rsp_ready, ALU_Result, SR,
        input  req_ready, rsp_valid, rsp_data, rsp_sr, rsp_err, EXE_CMD, Val1, Val2, C
    );

    // Sequencer
    modport slave (
        input  req_valid, req_op, req_a, req_b, req_cin, rsp_ready, ALU_Result, SR,
        output req_ready, rsp_valid, rsp_data, rsp_sr, rsp_err, EXE_CMD, Val1, Val2, C
    );
endinterface

// File: rtl/alu_wide_seq.sv
// Runs one 2*WIDTH-bit operation as two WIDTH-bit ALU beats (low word, then high word)
// with the carry chained between beats, and returns the wide result plus merged NZCV.
module alu_wide_seq #(
    parameter int unsigned WIDTH = 32
) (
    input  logic          clk,
    input  logic          rst,
    alu_wide_seq_if.slave bus
);

    localparam int unsigned DW = 2 * WIDTH;

    localparam logic [3:0] OP_NOP = 4'b0000;
    localparam logic [3:0] OP_MOV = 4'b0001;
    localparam logic [3:0] OP_ADD = 4'b0010;
    localparam logic [3:0] OP_ADC = 4'b0011;
    localparam logic [3:0] OP_SUB = 4'b0100;
    localparam logic [3:0] OP_SBC = 4'b0101;
    localparam logic [3:0] OP_MVN = 4'b1001;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LO   = 2'd1,
        ST_HI   = 2'd2,
        ST_RESP = 2'd3
    } state_t;

    state_t state;
    state_t state_nxt;

    // Latched request (only the high words are needed after the low beat is launched)
    logic [3:0]       op_q;
    logic [WIDTH-1:0] a_hi_q;
    logic [WIDTH-1:0] b_hi_q;

    // Low-beat results
    logic [WIDTH-1:0] res_lo_q;
    logic             z_lo_q;

    // Response registers
    logic [DW-1:0]    rsp_data_q;
    logic [3:0]       rsp_sr_q;
    logic             rsp_err_q;

    // ALU drive registers and their next values
    logic [3:0]       exe_cmd_q;
    logic [3:0]       exe_cmd_d;
    logic [WIDTH-1:0] val1_q;
    logic [WIDTH-1:0] val1_d;
    logic [WIDTH-1:0] val2_q;
    logic [WIDTH-1:0] val2_d;
    logic             c_q;
    logic             c_d;

    logic accept_c;
    logic op_ok_c;

    // Carry into the low beat: caller's carry for ADC/SBC, no-borrow for SUB
    function automatic logic lo_carry(input logic [3:0] op, input logic cin);
        case (op)
            OP_ADC, OP_SBC: return cin;
            OP_SUB:         return 1'b1;
            default:        return 1'b0;
        endcase
    endfunction

    // High beat turns ADD/SUB into their carry-consuming forms
    function automatic logic [3:0] hi_cmd(input logic [3:0] op);
        case (op)
            OP_ADD:  return OP_ADC;
            OP_SUB:  return OP_SBC;
            default: return op;
        endcase
    endfunction

    assign accept_c = bus.req_valid && (state == ST_IDLE);
    assign op_ok_c  = (bus.req_op >= OP_MOV) && (bus.req_op <= OP_MVN);

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: begin
                if (accept_c) begin
                    state_nxt = op_ok_c ? ST_LO : ST_RESP;
                end
            end
            ST_LO:   state_nxt = ST_HI;
            ST_HI:   state_nxt = ST_RESP;
            ST_RESP: begin
                if (bus.rsp_ready) begin
                    state_nxt = ST_IDLE;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // ALU drive for the beat that the next state will run; idle values otherwise
    always_comb begin
        exe_cmd_d = OP_NOP;
        val1_d    = '0;
        val2_d    = '0;
        c_d       = 1'b0;
        if (accept_c && op_ok_c) begin
            exe_cmd_d = bus.req_op;
            val1_d    = bus.req_a[WIDTH-1:0];
            val2_d    = bus.req_b[WIDTH-1:0];
            c_d       = lo_carry(bus.req_op, bus.req_cin);
        end else if (state == ST_LO) begin
            exe_cmd_d = hi_cmd(op_q);
            val1_d    = a_hi_q;
            val2_d    = b_hi_q;
            c_d       = bus.SR[1];
        end
    end

    // ALU drive registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            exe_cmd_q <= OP_NOP;
            val1_q    <= '0;
            val2_q    <= '0;
            c_q       <= 1'b0;
        end else begin
            exe_cmd_q <= exe_cmd_d;
            val1_q    <= val1_d;
            val2_q    <= val2_d;
            c_q       <= c_d;
        end
    end

    // Operand latch, low-beat capture and response assembly
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            op_q       <= OP_NOP;
            a_hi_q     <= '0;
            b_hi_q     <= '0;
            res_lo_q   <= '0;
            z_lo_q     <= 1'b0;
            rsp_data_q <= '0;
            rsp_sr_q   <= '0;
            rsp_err_q  <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (accept_c && op_ok_c) begin
                        op_q   <= bus.req_op;
                        a_hi_q <= bus.req_a[DW-1:WIDTH];
                        b_hi_q <= bus.req_b[DW-1:WIDTH];
                    end else if (accept_c) begin
                        rsp_data_q <= '0;
                        rsp_sr_q   <= '0;
                        rsp_err_q  <= 1'b1;
                    end
                end
                ST_LO: begin
                    res_lo_q <= bus.ALU_Result;
                    z_lo_q   <= bus.SR[2];
                end
                ST_HI: begin
                    rsp_data_q <= {bus.ALU_Result, res_lo_q};
                    rsp_sr_q   <= {bus.SR[3], z_lo_q & bus.SR[2], bus.SR[1], bus.SR[0]};
                    rsp_err_q  <= 1'b0;
                end
                default: ;
            endcase
        end
    end

    assign bus.req_ready = (state == ST_IDLE);
    assign bus.rsp_valid = (state == ST_RESP);
    assign bus.rsp_data  = rsp_data_q;
    assign bus.rsp_sr    = rsp_sr_q;
    assign bus.rsp_err   = rsp_err_q;
    assign bus.EXE_CMD   = exe_cmd_q;
    assign bus.Val1      = val1_q;
    assign bus.Val2      = val2_q;
    assign bus.C         = c_q;

endmodule

// File: tb/tb_alu_wide_seq.sv
// Directed bench for alu_wide_seq with a reference 32-bit ALU closing the loop.
module tb_alu_wide_seq;

    localparam int unsigned W = 32;

    logic clk = 1'b0;
    logic rst;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    alu_wide_seq_if #(.WIDTH(W)) bus ();

    alu_wide_seq #(.WIDTH(W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Reference ALU: ARM-style, SUB/SBC as A + ~B + carry
    logic [W:0]   alu_sum;
    logic [W-1:0] alu_opb;
    logic [W-1:0] alu_res;
    logic         alu_cin;
    logic         alu_arith;
    logic         alu_cf;
    logic         alu_vf;

    always_comb begin
        alu_opb   = bus.Val2;
        alu_cin   = 1'b0;
        alu_arith = 1'b0;
        alu_sum   = '0;
        alu_res   = '0;
        alu_cf    = 1'b0;
        alu_vf    = 1'b0;
        case (bus.EXE_CMD)
            4'b0001: alu_res = bus.Val2;
            4'b1001: alu_res = ~bus.Val2;
            4'b0010: alu_arith = 1'b1;
            4'b0011: begin alu_arith = 1'b1; alu_cin = bus.C; end
            4'b0100: begin alu_arith = 1'b1; alu_opb = ~bus.Val2; alu_cin = 1'b1; end
            4'b0101: begin alu_arith = 1'b1; alu_opb = ~bus.Val2; alu_cin = bus.C; end
            4'b0110: alu_res = bus.Val1 & bus.Val2;
            4'b0111: alu_res = bus.Val1 | bus.Val2;
            4'b1000: alu_res = bus.Val1 ^ bus.Val2;
            default: alu_res = '0;
        endcase
        if (alu_arith) begin
            alu_sum = {1'b0, bus.Val1} + {1'b0, alu_opb} + {{W{1'b0}}, alu_cin};
            alu_res = alu_sum[W-1:0];
            alu_cf  = alu_sum[W];
            alu_vf  = (bus.Val1[W-1] == alu_opb[W-1]) && (alu_res[W-1] != bus.Val1[W-1]);
        end
    end

    assign bus.ALU_Result = alu_res;
    assign bus.SR         = {alu_res[W-1], (alu_res == '0), alu_cf, alu_vf};

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Present a request and return #1 after the edge that accepts it
    task automatic issue(input logic [3:0] op, input logic [63:0] a, input logic [63:0] b,
                         input logic cin);
        int budget = 20;
        @(negedge clk);
        bus.req_valid = 1'b1;
        bus.req_op    = op;
        bus.req_a     = a;
        bus.req_b     = b;
        bus.req_cin   = cin;
        while (!bus.req_ready && budget > 0) begin
            @(negedge clk);
            budget--;
        end
        check("accept_in_time", 64'(budget > 0), 64'd1);
        @(posedge clk);
        #1;
        bus.req_valid = 1'b0;
    endtask

    task automatic beat(input string tag, input logic [3:0] cmd, input logic [31:0] v1,
                        input logic [31:0] v2, input logic c);
        check({tag, ".cmd"},  64'(bus.EXE_CMD),   64'(cmd));
        check({tag, ".val1"}, 64'(bus.Val1),      64'(v1));
        check({tag, ".val2"}, 64'(bus.Val2),      64'(v2));
        check({tag, ".c"},    64'(bus.C),         64'(c));
        check({tag, ".nrsp"}, 64'(bus.rsp_valid), 64'd0);
    endtask

    task automatic expect_rsp(input string tag, input logic [63:0] data, input logic [3:0] sr,
                              input logic err);
        check({tag, ".valid"}, 64'(bus.rsp_valid), 64'd1);
        check({tag, ".data"},  bus.rsp_data,       data);
        check({tag, ".sr"},    64'(bus.rsp_sr),    64'(sr));
        check({tag, ".err"},   64'(bus.rsp_err),   64'(err));
        check({tag, ".idle"},  64'(bus.EXE_CMD),   64'd0);
    endtask

    // Full valid op: LO beat, HI beat, response two edges after the accepting edge
    task automatic run_valid(input string tag, input logic [3:0] op, input logic [63:0] a,
                             input logic [63:0] b, input logic cin,
                             input logic [3:0] lo_cmd, input logic lo_c,
                             input logic [3:0] hi_cmd, input logic hi_c,
                             input logic [63:0] data, input logic [3:0] sr);
        issue(op, a, b, cin);
        beat({tag, ".lo"}, lo_cmd, a[31:0], b[31:0], lo_c);
        @(posedge clk); #1;
        beat({tag, ".hi"}, hi_cmd, a[63:32], b[63:32], hi_c);
        @(posedge clk); #1;
        expect_rsp(tag, data, sr, 1'b0);
    endtask

    task automatic finish_rsp(input string tag);
        @(negedge clk);
        bus.rsp_ready = 1'b1;
        @(posedge clk); #1;
        bus.rsp_ready = 1'b0;
        check({tag, ".done_nvalid"}, 64'(bus.rsp_valid), 64'd0);
        check({tag, ".done_ready"},  64'(bus.req_ready), 64'd1);
    endtask

    initial begin
        rst           = 1'b1;
        bus.req_valid = 1'b0;
        bus.req_op    = 4'b0000;
        bus.req_a     = '0;
        bus.req_b     = '0;
        bus.req_cin   = 1'b0;
        bus.rsp_ready = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk); #1;

        check("rst.req_ready", 64'(bus.req_ready), 64'd1);
        check("rst.rsp_valid", 64'(bus.rsp_valid), 64'd0);
        check("rst.rsp_data",  bus.rsp_data,       64'd0);
        check("rst.exe_cmd",   64'(bus.EXE_CMD),   64'd0);
        check("rst.val1",      64'(bus.Val1),      64'd0);
        check("rst.c",         64'(bus.C),         64'd0);

        // Carry ripples from low word into high word
        run_valid("add_carry", 4'b0010, 64'h00000000_FFFFFFFF, 64'h00000000_00000001, 1'b0,
                  4'b0010, 1'b0, 4'b0011, 1'b1, 64'h00000001_00000000, 4'b0000);
        finish_rsp("add_carry");

        // Equal operands: zero result, no borrow
        run_valid("sub_eq", 4'b0100, 64'h12345678_9ABCDEF0, 64'h12345678_9ABCDEF0, 1'b0,
                  4'b0100, 1'b1, 4'b0101, 1'b1, 64'd0, 4'b0110);
        finish_rsp("sub_eq");

        run_valid("eor_eq", 4'b1000, 64'hFFFF0000_0000FFFF, 64'hFFFF0000_0000FFFF, 1'b0,
                  4'b1000, 1'b0, 4'b1000, 1'b0, 64'd0, 4'b0100);
        finish_rsp("eor_eq");

        // ADD 13+15 then hold the response while another request waits
        run_valid("add_small", 4'b0010, 64'd13, 64'd15, 1'b0,
                  4'b0010, 1'b0, 4'b0011, 1'b0, 64'd28, 4'b0000);
        @(negedge clk);
        bus.req_valid = 1'b1;
        bus.req_op    = 4'b1001;
        bus.req_a     = 64'd0;
        bus.req_b     = 64'd0;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            check("bp.valid", 64'(bus.rsp_valid), 64'd1);
            check("bp.data",  bus.rsp_data,       64'd28);
            check("bp.ready", 64'(bus.req_ready), 64'd0);
        end
        @(negedge clk);
        bus.rsp_ready = 1'b1;
        @(posedge clk); #1;
        bus.rsp_ready = 1'b0;
        check("bp.release_nvalid", 64'(bus.rsp_valid), 64'd0);
        check("bp.release_ready",  64'(bus.req_ready), 64'd1);
        @(posedge clk); #1;
        bus.req_valid = 1'b0;
        beat("mvn.lo", 4'b1001, 32'd0, 32'd0, 1'b0);
        @(posedge clk); #1;
        beat("mvn.hi", 4'b1001, 32'd0, 32'd0, 1'b0);
        @(posedge clk); #1;
        expect_rsp("mvn", 64'hFFFFFFFF_FFFFFFFF, 4'b1000, 1'b0);
        finish_rsp("mvn");

        // Unsupported op: immediate error response, no ALU beats
        issue(4'b1111, 64'h1, 64'h2, 1'b0);
        expect_rsp("bad_op", 64'd0, 4'b0000, 1'b1);
        finish_rsp("bad_op");
        check("bad_op.after_cmd", 64'(bus.EXE_CMD), 64'd0);

        // Reset in the middle of the high beat
        issue(4'b0010, 64'h11111111_22222222, 64'h00000000_00000001, 1'b0);
        @(posedge clk); #1;
        check("abort.in_hi_cmd",  64'(bus.EXE_CMD), 64'd3);
        check("abort.in_hi_val1", 64'(bus.Val1),    64'h11111111);
        #1 rst = 1'b1;
        #1;
        check("abort.cmd",   64'(bus.EXE_CMD),   64'd0);
        check("abort.val1",  64'(bus.Val1),      64'd0);
        check("abort.c",     64'(bus.C),         64'd0);
        check("abort.valid", 64'(bus.rsp_valid), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk); #1;
        check("abort.no_rsp", 64'(bus.rsp_valid), 64'd0);
        check("abort.ready",  64'(bus.req_ready), 64'd1);

        run_valid("mov_after", 4'b0001, 64'd0, 64'hDEADBEEF_00000001, 1'b0,
                  4'b0001, 1'b0, 4'b0001, 1'b0, 64'hDEADBEEF_00000001, 4'b1000);
        finish_rsp("mov_after");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
